// File: rtl/lvds_link_pkg.sv
// Shared definitions for the inter-board LVDS photon-bin link (TX shaper and RX trigger).
// Bin order: bit 0 of every word is the earliest bin in time.
package lvds_link_pkg;

  localparam int NBINS_DEF = 8;
  localparam int CNTW_DEF  = 8;

  // Lower half ones, upper half zeros: gives the receiver one clean transition per word.
  localparam logic [NBINS_DEF-1:0] TRAIN_PAT_DEF =
    {{(NBINS_DEF/2){1'b0}}, {(NBINS_DEF/2){1'b1}}};

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TRAIN = 2'd1,
    MODE_SHAPE = 2'd2
  } tx_mode_e;

endpackage

// File: rtl/lvds_phot_shaper.sv
// Combinational walk over one word of edge bins, applying pulse width and dead time
// starting from the counters carried in from the previous word.
module lvds_phot_shaper #(
  parameter int NBINS = 8,
  parameter int CNTW  = 8
) (
  input  logic [NBINS-1:0] edges,
  input  logic [CNTW-1:0]  fire_in,
  input  logic [CNTW-1:0]  dead_in,
  input  logic [CNTW-1:0]  firingticks,
  input  logic [CNTW-1:0]  deadticks,
  output logic [NBINS-1:0] word,
  output logic [CNTW-1:0]  fire_out,
  output logic [CNTW-1:0]  dead_out,
  output logic [NBINS-1:0] accepted
);

  logic [CNTW-1:0] fire_load;

  // A zero pulse width still produces a single-bin pulse.
  assign fire_load = (firingticks == '0) ? '0 : firingticks - CNTW'(1);

  always_comb begin
    fire_out = fire_in;
    dead_out = dead_in;
    word     = '0;
    accepted = '0;
    for (int j = 0; j < NBINS; j++) begin
      if (fire_out != '0) begin
        word[j]  = 1'b1;
        fire_out = fire_out - CNTW'(1);
        if (fire_out == '0) dead_out = deadticks;
      end else if (dead_out != '0) begin
        dead_out = dead_out - CNTW'(1);
      end else if (edges[j]) begin
        accepted[j] = 1'b1;
        word[j]     = 1'b1;
        fire_out    = fire_load;
        if (fire_load == '0) dead_out = deadticks;
      end
    end
  end

endmodule

// File: rtl/lvds_phot_tx.sv
// LVDS photon-bin transmitter: edge detect, pulse/dead-time shaping, training pattern
// and saturating hit counter. Two-cycle fixed latency from samples to lvds_tx.
module lvds_phot_tx
  import lvds_link_pkg::*;
#(
  parameter int               NBINS     = NBINS_DEF,
  parameter int               CNTW      = CNTW_DEF,
  parameter logic [NBINS-1:0] TRAIN_PAT = {{(NBINS/2){1'b0}}, {(NBINS/2){1'b1}}}
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [NBINS-1:0] samples,
  input  logic [CNTW-1:0]  firingticks,
  input  logic [CNTW-1:0]  deadticks,
  input  logic             enable,
  input  logic             train,
  input  logic             resetcount,
  output logic [NBINS-1:0] lvds_tx,
  output logic             busy,
  output logic [31:0]      hit_count
);

  localparam int HW = $clog2(NBINS + 1);

  logic             prev_msb;
  logic [NBINS-1:0] edges_d, edge_q;
  logic [NBINS-1:0] shaped, accepted, tx_d;
  logic [CNTW-1:0]  fire_cnt, dead_cnt, fire_nx, dead_nx, fire_d, dead_d;
  logic [HW-1:0]    hits;
  logic [32:0]      hit_sum;
  logic [31:0]      hit_cnt_q, hit_sat, hit_d;
  tx_mode_e         mode;

  // Bin -1 of this word is the last bin of the previous word.
  assign edges_d = samples & ~{samples[NBINS-2:0], prev_msb};

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      prev_msb <= 1'b0;
      edge_q   <= '0;
    end else begin
      prev_msb <= samples[NBINS-1];
      edge_q   <= edges_d;
    end
  end

  lvds_phot_shaper #(
    .NBINS (NBINS),
    .CNTW  (CNTW)
  ) u_shaper (
    .edges       (edge_q),
    .fire_in     (fire_cnt),
    .dead_in     (dead_cnt),
    .firingticks (firingticks),
    .deadticks   (deadticks),
    .word        (shaped),
    .fire_out    (fire_nx),
    .dead_out    (dead_nx),
    .accepted    (accepted)
  );

  always_comb begin
    hits = '0;
    for (int j = 0; j < NBINS; j++) hits = hits + HW'(accepted[j]);
  end

  always_comb begin
    hit_sum = {1'b0, hit_cnt_q} + 33'(hits);
    hit_sat = hit_sum[32] ? '1 : hit_sum[31:0];
  end

  always_comb begin
    if (train)       mode = MODE_TRAIN;
    else if (enable) mode = MODE_SHAPE;
    else             mode = MODE_OFF;
  end

  // Training and disable both leave the shaper idle so it restarts cleanly.
  always_comb begin
    tx_d   = '0;
    fire_d = '0;
    dead_d = '0;
    hit_d  = hit_cnt_q;
    case (mode)
      MODE_TRAIN: tx_d = TRAIN_PAT;
      MODE_SHAPE: begin
        tx_d   = shaped;
        fire_d = fire_nx;
        dead_d = dead_nx;
        hit_d  = hit_sat;
      end
      default: ;
    endcase
    if (resetcount) hit_d = '0;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      lvds_tx   <= '0;
      fire_cnt  <= '0;
      dead_cnt  <= '0;
      hit_cnt_q <= '0;
    end else begin
      lvds_tx   <= tx_d;
      fire_cnt  <= fire_d;
      dead_cnt  <= dead_d;
      hit_cnt_q <= hit_d;
    end
  end

  assign busy      = (fire_cnt | dead_cnt) != '0;
  assign hit_count = hit_cnt_q;

endmodule
